spi_xfer_ctrl: RTL and testbench
================================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 Parameter: DEPTH, 8, entries per FIFO (TX and RX each); power of two, 2..64.
REQ-002 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-003 Ports: rst  in  1  reset, asynchronous, active-low.
REQ-004 Ports: wr  in  1  push wdata/wfast into TX FIFO.
REQ-005 Ports: wdata  in  32  word to transmit.
REQ-006 Ports: wfast  in  1  per-word mode: 1 = 32-bit fast transfer, 0 = 8-bit slow transfer.
REQ-007 Ports: rd  in  1  pop RX FIFO head.
REQ-008 Ports: rdata  out  32  RX FIFO head, first-word fall-through; 0 when empty.
REQ-009 Ports: clr  in  1  clear sticky error flags.
REQ-010 Ports: cs_sel  in  1  software chip-select request.
REQ-011 Ports: tx_full, tx_empty, rx_full, rx_empty  out  1 each  FIFO status.
REQ-012 Ports: busy  out  1  transfer in flight (state != IDLE).
REQ-013 Ports: ovf, unf  out  1 each  sticky: push to full TX, pop of empty RX.
REQ-014 Ports: spi_start  out  1  one-cycle launch pulse to SPI engine.
REQ-015 Ports: spi_fast  out  1  mode of current transfer, held stable during transfer.
REQ-016 Ports: spi_dataTx  out  32  transmit word, held from launch until next launch.
REQ-017 Ports: spi_dataRx  in  32  received word, valid when spi_rdy high after transfer.
REQ-018 Ports: spi_rdy  in  1  SPI engine idle/done (registered; falls one cycle after spi_start).
REQ-019 Ports: cs_n  out  1  SPI chip select, active-low.

Function
REQ-020 States: IDLE, LAUNCH, WAIT, DONE; encoding free.
REQ-021 IDLE -> LAUNCH when TX non-empty, RX not full, spi_rdy=1; otherwise stay.
REQ-022 LAUNCH (1 cycle): spi_start=1, spi_dataTx/spi_fast loaded from TX head, TX pop; -> WAIT.
REQ-023 WAIT: ignore spi_rdy for first cycle (engine rdy still high); thereafter on spi_rdy=1 -> DONE.
REQ-024 DONE (1 cycle): push spi_dataRx into RX (space guaranteed by REQ-021); -> IDLE.
REQ-025 Minimum spacing between spi_start pulses: 4 cycles plus engine transfer time; only one transfer in flight.
REQ-026 Slow-mode words: only bits 7:0 transmitted; RX entry stores spi_dataRx as delivered (upper 24 bits zero).
REQ-027 FIFO pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full = MSBs differ and low bits equal; empty = equal.
REQ-028 wr while tx_full: word dropped, ovf set; rd while rx_empty: no pointer change, unf set.
REQ-029 wr and TX pop in same cycle: both occur; count unchanged; legal when full only if pop occurs (then accepted, ovf not set).
REQ-030 rd and RX push in same cycle: both occur; legal when rx_full only if rd pops (push cannot occur when full per REQ-021).
REQ-031 clr clears ovf/unf; clr with simultaneous error event: flag ends set.
REQ-032 Status outputs combinational from pointers; rdata combinational from RX head.

Reset
REQ-033 rst low: state IDLE, both FIFOs empty, spi_start=0, spi_fast=0, spi_dataTx=32'hFFFFFFFF, ovf=unf=0, cs_n=1; effective immediately, asynchronously.
REQ-034 Reset mid-transfer abandons the word; no RX push; engine is reset by the same rst.
REQ-035 FIFO storage arrays need no reset; only pointers reset.

Configuration
REQ-036 Macro SPI_XFER_AUTOCS_EN defined: cs_n = ~(cs_sel & (busy | ~tx_empty)), registered, so select drops one cycle after last DONE with TX empty.
REQ-037 Macro undefined: cs_n = ~cs_sel, registered; no dependence on busy or TX.

Verification
REQ-038 Reset, then wr 32'hA5A5A5A5 fast=1 with engine model rdy -> one spi_start, spi_dataTx=32'hA5A5A5A5, spi_fast=1; model returns 32'h12345678 -> rdata=32'h12345678, rx_empty=0.
REQ-039 Push DEPTH+1 words with engine stalled (spi_rdy held 0) -> tx_full=1 after DEPTH, last word dropped, ovf=1; clr -> ovf=0.
REQ-040 Fill RX (DEPTH transfers, no rd), 1 more TX word queued -> no spi_start until one rd; then exactly one launch.
REQ-041 Slow word 32'h000000C3 fast=0, model returns 8'h5A -> rdata=32'h0000005A; spi_fast=0 throughout transfer.
REQ-042 Assert rst low in WAIT -> cs_n=1, busy=0, tx_empty=rx_empty=1 same cycle; no RX push after release.
REQ-043 With SPI_XFER_AUTOCS_EN, cs_sel=1, 3 queued words -> cs_n low before first start, high one cycle after third DONE; without macro cs_n tracks cs_sel only.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: TX/RX word FIFOs sequencing one SPI engine transfer at a time; define SPI_XFER_AUTOCS_EN for automatic chip select
module spi_xfer_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic        wfast,
  input  logic        rd,
  output logic [31:0] rdata,
  input  logic        clr,
  input  logic        cs_sel,
  output logic        tx_full,
  output logic        tx_empty,
  output logic        rx_full,
  output logic        rx_empty,
  output logic        busy,
  output logic        ovf,
  output logic        unf,
  output logic        spi_start,
  output logic        spi_fast,
  output logic [31:0] spi_dataTx,
  input  logic [31:0] spi_dataRx,
  input  logic        spi_rdy,
  output logic        cs_n
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [32:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic skip, load, tx_push, tx_pop, rx_push, rx_pop;
  assign tx_empty = tx_wp == tx_rp;
  assign rx_empty = rx_wp == rx_rp;
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rdata    = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];
  assign tx_push  = wr & (~tx_full | tx_pop);
  assign rx_pop   = rd & ~rx_empty;
  assign load     = (state == IDLE) && (state_nx == LAUNCH);
  // FIFO storage, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= {wfast, wdata};
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= spi_dataRx;
  end
  // FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
    end
  end
  // sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (ovf & ~clr) | (wr & tx_full & ~tx_pop);
      unf <= (unf & ~clr) | (rd & rx_empty);
    end
  end
  // state register; skip masks the stale engine ready in the first WAIT cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      skip  <= 1'b0;
    end else begin
      state <= state_nx;
      skip  <= state == LAUNCH;
    end
  end
  // next-state logic
  always_comb begin
    state_nx = (state == IDLE)   ? ((~tx_empty & ~rx_full & spi_rdy) ? LAUNCH : IDLE) :
               (state == LAUNCH) ? WAIT :
               (state == WAIT)   ? ((~skip & spi_rdy) ? DONE : WAIT) : IDLE;
  end
  // state-decoded outputs and FIFO strobes
  always_comb begin
    spi_start = state == LAUNCH;
    busy      = state != IDLE;
    tx_pop    = state == LAUNCH;
    rx_push   = state == DONE;
  end
  // transmit word and mode captured as the launch begins so they are valid with spi_start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_dataTx <= 32'hFFFF_FFFF;
      spi_fast   <= 1'b0;
    end else if (load) begin
      {spi_fast, spi_dataTx} <= tx_mem[tx_rp[AW-1:0]];
    end
  end
  // registered chip select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cs_n <= 1'b1;
`ifdef SPI_XFER_AUTOCS_EN
    else cs_n <= ~(cs_sel & (busy | ~tx_empty));
`else
    else cs_n <= ~cs_sel;
`endif
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed scoreboard bench for spi_xfer_ctrl with a behavioural SPI engine
module tb_spi_xfer_ctrl;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, wfast = 1'b0, rd = 1'b0, clr = 1'b0, cs_sel = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, spi_dataTx, eng_data;
  logic tx_full, tx_empty, rx_full, rx_empty, busy, ovf, unf, spi_start, spi_fast, cs_n, spi_rdy;
  logic eng_rdy, stall = 1'b0;
  int lat = 2, cnt, n_chk = 0, n_fail = 0, n_start = 0, base;
  bit fast_seen;
  logic [32:0] exp_tx[$];
  logic [31:0] exp_rx[$], resp_q[$];

  spi_xfer_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wdata(wdata), .wfast(wfast), .rd(rd), .rdata(rdata),
    .clr(clr), .cs_sel(cs_sel), .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full),
    .rx_empty(rx_empty), .busy(busy), .ovf(ovf), .unf(unf), .spi_start(spi_start),
    .spi_fast(spi_fast), .spi_dataTx(spi_dataTx), .spi_dataRx(eng_data), .spi_rdy(spi_rdy),
    .cs_n(cs_n)
  );

  always #5 clk = ~clk;
  assign spi_rdy = eng_rdy & ~stall;

  // engine model: ready drops the cycle after start, returns after lat cycles unless stalled
  always @(posedge clk or negedge rst)
    if (!rst) begin
      eng_rdy <= 1'b1; cnt <= 0; eng_data <= '0;
    end else if (spi_start) begin
      eng_rdy <= 1'b0; cnt <= lat;
      eng_data <= (resp_q.size() > 0) ? resp_q.pop_front() : 32'h0;
    end else if (!eng_rdy && !stall) begin
      if (cnt == 0) eng_rdy <= 1'b1; else cnt <= cnt - 1;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compares every launch and every RX pop against the scoreboard queues
  always @(negedge clk) if (rst) begin
    if (busy && spi_fast) fast_seen = 1'b1;
    if (spi_start) begin
      n_start++;
      if (exp_tx.size() == 0) chk("unexpected_start", {spi_fast, spi_dataTx[30:0]}, 32'hFFFF_FFFF);
      else begin
        logic [32:0] e;
        e = exp_tx.pop_front();
        chk("start_data", spi_dataTx, e[31:0]);
        chk("start_fast", {31'b0, spi_fast}, {31'b0, e[32]});
      end
`ifdef SPI_XFER_AUTOCS_EN
      chk("autocs_low_at_start", {31'b0, cs_n}, 32'h0);
`endif
    end
    if (rd && !rx_empty) begin
      if (exp_rx.size() == 0) chk("unexpected_rx", rdata, 32'hxxxx_xxxx);
      else chk("rx_pop_data", rdata, exp_rx.pop_front());
    end
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic push(input logic [31:0] d, input logic f);
    wr = 1'b1; wdata = d; wfast = f; tick; wr = 1'b0;
  endtask
  task automatic pop1; rd = 1'b1; tick; rd = 1'b0; endtask
  task automatic xfer(input logic [31:0] d, input logic f, input logic [31:0] r);
    exp_tx.push_back({f, d}); resp_q.push_back(r); exp_rx.push_back(r); push(d, f);
  endtask

  initial begin
    #2 rst = 1'b0;
    #3;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_tx_empty", {31'b0, tx_empty}, 1);
    chk("rst_rx_empty", {31'b0, rx_empty}, 1);
    chk("rst_full", {30'b0, tx_full, rx_full}, 0);
    chk("rst_flags", {30'b0, ovf, unf}, 0);
    chk("rst_start_fast", {30'b0, spi_start, spi_fast}, 0);
    chk("rst_dataTx", spi_dataTx, 32'hFFFF_FFFF);
    chk("rst_cs_n", {31'b0, cs_n}, 1);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1 rst = 1'b1;
    tick;
    // single fast word
    xfer(32'hA5A5_A5A5, 1'b1, 32'h1234_5678);
    for (int i = 0; i < 100 && rx_empty; i++) tick;
    chk("fast_rx_empty", {31'b0, rx_empty}, 0);
    chk("fast_rdata", rdata, 32'h1234_5678);
    chk("fast_starts", n_start, 1);
    pop1;
    chk("fast_rx_empty_after_rd", {31'b0, rx_empty}, 1);
    // single slow word
    fast_seen = 1'b0;
    xfer(32'h0000_00C3, 1'b0, 32'h0000_005A);
    for (int i = 0; i < 100 && rx_empty; i++) tick;
    chk("slow_rdata", rdata, 32'h0000_005A);
    chk("slow_fast_seen", {31'b0, fast_seen}, 0);
    pop1;
    // TX overflow with stalled engine
    stall = 1'b1;
    base = n_start;
    for (int i = 0; i < DEPTH; i++) xfer(32'hB000_0000 + i, 1'b1, 32'h1000_0000 + i);
    chk("ovf_tx_full", {31'b0, tx_full}, 1);
    chk("ovf_before", {31'b0, ovf}, 0);
    push(32'hDEAD_BEEF, 1'b1);
    chk("ovf_set", {31'b0, ovf}, 1);
    chk("ovf_still_full", {31'b0, tx_full}, 1);
    chk("ovf_no_start", n_start, base);
    clr = 1'b1; tick; clr = 1'b0;
    chk("ovf_cleared", {31'b0, ovf}, 0);
    // RX fills, further launch held until one pop
    stall = 1'b0;
    for (int i = 0; i < 1000 && !rx_full; i++) tick;
    chk("rxfull_set", {31'b0, rx_full}, 1);
    chk("rxfull_starts", n_start, base + DEPTH);
    xfer(32'hC0FF_EE00, 1'b1, 32'h2000_0000);
    repeat (20) tick;
    chk("rxfull_held", n_start, base + DEPTH);
    chk("rxfull_tx_pending", {31'b0, tx_empty}, 0);
    pop1;
    for (int i = 0; i < 50 && n_start == base + DEPTH; i++) tick;
    repeat (20) tick;
    chk("rxfull_one_launch", n_start, base + DEPTH + 1);
    chk("rxfull_again", {31'b0, rx_full}, 1);
    for (int i = 0; i < DEPTH; i++) pop1;
    chk("drain_rx_empty", {31'b0, rx_empty}, 1);
    chk("drain_exp_rx", exp_rx.size(), 0);
    // underflow and clear priority
    pop1;
    chk("unf_set", {31'b0, unf}, 1);
    rd = 1'b1; clr = 1'b1; tick; rd = 1'b0; clr = 1'b0;
    chk("unf_clr_with_err", {31'b0, unf}, 1);
    clr = 1'b1; tick; clr = 1'b0;
    chk("unf_cleared", {31'b0, unf}, 0);
    // reset during WAIT
    cs_sel = 1'b1;
    lat = 10;
    exp_tx.push_back({1'b1, 32'h7777_7777}); resp_q.push_back(32'h0BAD_F00D);
    push(32'h7777_7777, 1'b1);
    for (int i = 0; i < 50 && !(busy && !spi_start); i++) tick;
    tick;
    chk("wait_busy", {31'b0, busy}, 1);
    chk("wait_cs_low", {31'b0, cs_n}, 0);
    rst = 1'b0; #1;
    chk("mid_rst_cs_n", {31'b0, cs_n}, 1);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_empty", {30'b0, tx_empty, rx_empty}, 3);
    cs_sel = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    base = n_start;
    repeat (20) tick;
    chk("post_rst_rx_empty", {31'b0, rx_empty}, 1);
    chk("post_rst_no_start", n_start, base);
    lat = 2;
`ifdef SPI_XFER_AUTOCS_EN
    cs_sel = 1'b1; tick; tick;
    chk("autocs_idle_high", {31'b0, cs_n}, 1);
    for (int i = 0; i < 3; i++) xfer(32'h3000_0000 + i, 1'b1, 32'h4000_0000 + i);
    for (int i = 0; i < 200 && (busy || !tx_empty || n_start != base + 3); i++) tick;
    chk("autocs_hold_after_done", {31'b0, cs_n}, 0);
    tick;
    chk("autocs_release", {31'b0, cs_n}, 1);
    for (int i = 0; i < 3; i++) pop1;
    cs_sel = 1'b0;
`else
    cs_sel = 1'b1; tick;
    chk("cs_follow_low", {31'b0, cs_n}, 0);
    cs_sel = 1'b0; tick;
    chk("cs_follow_high", {31'b0, cs_n}, 1);
`endif
    chk("exp_tx_consumed", exp_tx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: test did not complete");
    $fatal(1);
  end
endmodule
